// File: rtl/flash_wb_arbiter_if.sv
// Wishbone link between one master and one slave as seen by the flash arbiter.
// The arbiter binds the two CPU-side links with the slave modport and the flash
// controller link with the master modport.
interface flash_wb_arbiter_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [3:0]  sel;
    logic        ack;

    modport master (
        output adr, dat_w, we, stb, cyc, sel,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, we, stb, cyc, sel,
        output dat_r, ack
    );
endinterface

// File: rtl/flash_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single flash controller.
// m0 is the instruction-fetch port, m1 the data port. After every completed or
// aborted cycle the slave request is held low for one RELEASE cycle.
// Optional slave-ack watchdog: define FLASH_ARB_TIMEOUT_EN to enable it.
module flash_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    flash_wb_arbiter_if.slave   m0,
    flash_wb_arbiter_if.slave   m1,
    flash_wb_arbiter_if.master  s,
    output logic [1:0]          gnt_o,
    output logic                timeout_o
);

    typedef enum logic [2:0] {
        StIdle,
        StBusy0,
        StBusy1,
        StAbort,
        StRelease
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        last_q, last_d;  // 1: m1 was granted last
    logic        req0, req1;
    logic        expire;
    logic        busy0, busy1;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    assign req0  = m0.cyc & m0.stb;
    assign req1  = m1.cyc & m1.stb;
    assign busy0 = (state_q == StBusy0);
    assign busy1 = (state_q == StBusy1);
    assign gnt_o = gnt_q;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam logic [7:0] Limit = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q, cnt_d;
    logic       waiting;

    assign waiting = busy0 | busy1 | (state_q == StAbort);
    // A normal slave ack in the expiry cycle wins over the watchdog.
    assign expire  = waiting & (cnt_q == Limit) & ~s.ack;

    // Watchdog count: zero on entry to BUSY/ABORT, +1 per cycle spent waiting there.
    always_comb begin
        cnt_d = 8'd0;
        if ((state_d == state_q) &&
            (state_d == StBusy0 || state_d == StBusy1 || state_d == StAbort)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    assign timeout_o = expire;

    // Next state, grant and round-robin pointer.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (req0 && (!req1 || last_q)) begin
                    state_d = StBusy0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = StBusy1;
                    last_d  = 1'b1;
                end
            end
            StBusy0: begin
                if (s.ack || expire) begin
                    state_d = StRelease;
                end else if (!req0) begin
                    state_d = StAbort;
                end
            end
            StBusy1: begin
                if (s.ack || expire) begin
                    state_d = StRelease;
                end else if (!req1) begin
                    state_d = StAbort;
                end
            end
            StAbort: begin
                if (s.ack || expire) begin
                    state_d = StRelease;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        gnt_d = {state_d == StBusy1, state_d == StBusy0};
    end

    // Arbiter state registers; reset pointer names m1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Bus steering: granted master drives the slave, slave response fans back out.
    always_comb begin
        s.adr   = 32'd0;
        s.dat_w = 32'd0;
        s.we    = 1'b0;
        s.stb   = 1'b0;
        s.cyc   = 1'b0;
        s.sel   = 4'd0;
        if (busy0) begin
            s.adr   = m0.adr;
            s.dat_w = m0.dat_w;
            s.we    = m0.we;
            s.stb   = m0.stb;
            s.cyc   = m0.cyc;
            s.sel   = m0.sel;
        end else if (busy1) begin
            s.adr   = m1.adr;
            s.dat_w = m1.dat_w;
            s.we    = m1.we;
            s.stb   = m1.stb;
            s.cyc   = m1.cyc;
            s.sel   = m1.sel;
        end

        m0.dat_r = s.dat_r;
        m1.dat_r = s.dat_r;
        m0.ack   = busy0 & s.ack;
        m1.ack   = busy1 & s.ack;
        // Watchdog expiry completes the stalled cycle with an all-ones error word.
        if (expire && busy0) begin
            m0.dat_r = 32'hFFFF_FFFF;
            m0.ack   = 1'b1;
        end
        if (expire && busy1) begin
            m1.dat_r = 32'hFFFF_FFFF;
            m1.ack   = 1'b1;
        end
    end

endmodule
